// File: rtl/mcd_snd_tx_if.sv
// Signal bundle between the MCD sound transmitter and its mixer/DAC neighbours.
// The master side is the transmitter itself.
interface mcd_snd_tx_if;
    logic        mute;
    logic [15:0] snd_l;
    logic [15:0] snd_r;
    logic        snd_clk;
    logic        snd_next_sample;
    logic        i2s_bck;
    logic        i2s_lrck;
    logic        i2s_sdat;

    modport master (
        input  mute, snd_l, snd_r,
        output snd_clk, snd_next_sample, i2s_bck, i2s_lrck, i2s_sdat
    );

    modport slave (
        output mute, snd_l, snd_r,
        input  snd_clk, snd_next_sample, i2s_bck, i2s_lrck, i2s_sdat
    );
endinterface

// File: rtl/mcd_snd_tx.sv
// MCD sound output: fractional DAC tick generator plus stereo I2S serialiser.
// Define MCD_SND_TX_LJ_EN for left-justified output instead of standard I2S.
module mcd_snd_tx #(
    parameter int unsigned PHASE_W   = 24,
    parameter int unsigned PHASE_INC = 7576344
) (
    input logic           clk,
    input logic           rst,
    mcd_snd_tx_if.master  bus
);

    logic [PHASE_W-1:0] acc_q;
    logic [PHASE_W:0]   acc_sum;
    logic               carry;
    logic [8:0]         t_q;
    logic [8:0]         t_d;
    logic [15:0]        sh_l_q;
    logic [15:0]        sh_r_q;
    logic [15:0]        cap_l;
    logic [15:0]        cap_r;
    logic [15:0]        src_l;
    logic [15:0]        src_r;
    logic               capture;
    logic [5:0]         bit_pos;
    logic               lrck_d;
    logic               sdat_d;
    logic               snd_clk_q;
    logic               next_q;
    logic               bck_q;
    logic               lrck_q;
    logic               sdat_q;

    assign acc_sum = {1'b0, acc_q} + (PHASE_W + 1)'(PHASE_INC);
    assign carry   = acc_sum[PHASE_W];
    assign t_d     = t_q + 9'd1;

`ifdef MCD_SND_TX_LJ_EN
    localparam logic [8:0] CapT = 9'd0;
    assign bit_pos = t_d[8:3];
    assign lrck_d  = ~t_d[8];
`else
    localparam logic [8:0] CapT = 9'd4;
    // Standard I2S: data lags word select by one BCK.
    assign bit_pos = t_d[8:3] - 6'd1;
    assign lrck_d  = t_d[8];
`endif

    assign cap_l   = bus.mute ? 16'd0 : bus.snd_l;
    assign cap_r   = bus.mute ? 16'd0 : bus.snd_r;
    assign capture = carry && (t_d == CapT);
    // In left-justified mode the MSB leaves on the capture tick itself.
    assign src_l   = capture ? cap_l : sh_l_q;
    assign src_r   = capture ? cap_r : sh_r_q;

    always_comb begin
        sdat_d = 1'b0;
        unique case (bit_pos[5:4])
            2'b00:   sdat_d = src_l[~bit_pos[3:0]];
            2'b10:   sdat_d = src_r[~bit_pos[3:0]];
            default: sdat_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            t_q       <= 9'd511;
            sh_l_q    <= '0;
            sh_r_q    <= '0;
            snd_clk_q <= 1'b0;
            next_q    <= 1'b0;
            bck_q     <= 1'b0;
            lrck_q    <= 1'b1;
            sdat_q    <= 1'b0;
        end else begin
            acc_q     <= acc_sum[PHASE_W-1:0];
            snd_clk_q <= carry;
            next_q    <= carry && (t_q == 9'd511);
            if (carry) begin
                t_q    <= t_d;
                bck_q  <= t_d[2];
                lrck_q <= lrck_d;
                if (t_d[2:0] == 3'd0) begin
                    sdat_q <= sdat_d;
                end
                if (capture) begin
                    sh_l_q <= cap_l;
                    sh_r_q <= cap_r;
                end
            end
        end
    end

    assign bus.snd_clk         = snd_clk_q;
    assign bus.snd_next_sample = next_q;
    assign bus.i2s_bck         = bck_q;
    assign bus.i2s_lrck        = lrck_q;
    assign bus.i2s_sdat        = sdat_q;

endmodule

// File: tb/tb_mcd_snd_tx.sv
// Directed bench for mcd_snd_tx: decodes the serial frames and checks tick timing.
module tb_mcd_snd_tx;

    localparam longint unsigned INC = 7576344;
`ifdef MCD_SND_TX_LJ_EN
    localparam int OFF = 0;
    localparam bit LJ  = 1'b1;
`else
    localparam int OFF = 1;
    localparam bit LJ  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    mcd_snd_tx_if bus ();
    mcd_snd_tx_if bus_f ();

    mcd_snd_tx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    mcd_snd_tx #(
        .PHASE_W  (24),
        .PHASE_INC(4194304)
    ) dut_f (
        .clk (clk),
        .rst (rst),
        .bus (bus_f.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame receiver on the default-rate instance.
    logic        sd [64];
    logic        lr [64];
    int          bidx = 0;
    int          tick_cnt = 0;
    int          frames = 0;
    int          frame_bits = 0;
    int          frame_ticks = 0;
    int          orphan = 0;
    int          seen_tick = 0;
    int          first_nxt = 0;
    logic        bck_prev = 1'b0;
    logic [15:0] dec_l, dec_r;
    logic [15:0] acc_l, acc_r;
    logic        zero_ok, lr_ok, zok, lok;
    longint      clk_cnt = 0;
    longint      tick_total = 0;

    always @(negedge clk) begin
        if (!rst) begin
            bidx = 0; tick_cnt = 0; seen_tick = 0; bck_prev = 1'b0;
            clk_cnt = 0; tick_total = 0;
        end else begin
            clk_cnt++;
            if (bus.snd_next_sample && !bus.snd_clk) orphan++;
            if (bus.i2s_bck && !bck_prev) begin
                if (bidx < 64) begin
                    sd[bidx] = bus.i2s_sdat;
                    lr[bidx] = bus.i2s_lrck;
                end
                bidx++;
            end
            bck_prev = bus.i2s_bck;
            if (bus.snd_clk) begin
                tick_total++;
                if (seen_tick == 0) begin
                    seen_tick = 1;
                    first_nxt = int'(bus.snd_next_sample);
                end
                if (bus.snd_next_sample) begin
                    acc_l = '0; acc_r = '0; zok = 1'b1; lok = 1'b1;
                    for (int i = 0; i < 64; i++) begin
                        if (i >= OFF && i < OFF + 16) acc_l = {acc_l[14:0], sd[i]};
                        else if (i >= 32 + OFF && i < 48 + OFF) acc_r = {acc_r[14:0], sd[i]};
                        else if (sd[i] !== 1'b0) zok = 1'b0;
                        if (lr[i] !== ((i >= 32) ^ LJ)) lok = 1'b0;
                    end
                    dec_l = acc_l; dec_r = acc_r; zero_ok = zok; lr_ok = lok;
                    frame_bits  = bidx;
                    frame_ticks = tick_cnt + 1;
                    bidx = 0; tick_cnt = 0;
                    frames++;
                end else begin
                    tick_cnt++;
                end
            end
        end
    end

    // Tick spacing and BCK duty on the quarter-rate instance.
    int cyc_f = 0, last_tick_f = 0, last_edge_f = 0, tick_ok_f = 0, edge_ok_f = 0;
    int gap_min = 1000, gap_max = 0, hi_min = 1000, hi_max = 0, lo_min = 1000, lo_max = 0;
    logic bck_prev_f = 1'b0;

    always @(negedge clk) begin
        cyc_f++;
        if (!rst) begin
            tick_ok_f = 0; edge_ok_f = 0; bck_prev_f = 1'b0;
        end else begin
            if (bus_f.snd_clk) begin
                if (tick_ok_f != 0) begin
                    if (cyc_f - last_tick_f < gap_min) gap_min = cyc_f - last_tick_f;
                    if (cyc_f - last_tick_f > gap_max) gap_max = cyc_f - last_tick_f;
                end
                tick_ok_f = 1; last_tick_f = cyc_f;
            end
            if (bus_f.i2s_bck != bck_prev_f) begin
                if (edge_ok_f != 0) begin
                    if (bus_f.i2s_bck) begin
                        if (cyc_f - last_edge_f < lo_min) lo_min = cyc_f - last_edge_f;
                        if (cyc_f - last_edge_f > lo_max) lo_max = cyc_f - last_edge_f;
                    end else begin
                        if (cyc_f - last_edge_f < hi_min) hi_min = cyc_f - last_edge_f;
                        if (cyc_f - last_edge_f > hi_max) hi_max = cyc_f - last_edge_f;
                    end
                end
                edge_ok_f = 1; last_edge_f = cyc_f;
            end
            bck_prev_f = bus_f.i2s_bck;
        end
    end

    task automatic wait_frame();
        int n0 = frames;
        int k = 0;
        while (frames == n0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("frame_timeout", 32'(frames != n0), 32'd1);
    endtask

    task automatic wait_t(input int t);
        int k = 0;
        while (tick_cnt != t && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("wait_t_timeout", 32'(tick_cnt == t), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] el, input logic [15:0] er);
        wait_frame();
        check({tag, "_left"},  32'(dec_l), 32'(el));
        check({tag, "_right"}, 32'(dec_r), 32'(er));
        check({tag, "_bits"},  32'(frame_bits), 32'd64);
        check({tag, "_ticks"}, 32'(frame_ticks), 32'd512);
        check({tag, "_zeros"}, 32'(zero_ok), 32'd1);
        check({tag, "_lrck"},  32'(lr_ok), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_snd_clk"}, 32'(bus.snd_clk), 32'd0);
        check({tag, "_next"},    32'(bus.snd_next_sample), 32'd0);
        check({tag, "_bck"},     32'(bus.i2s_bck), 32'd0);
        check({tag, "_lrck"},    32'(bus.i2s_lrck), 32'd1);
        check({tag, "_sdat"},    32'(bus.i2s_sdat), 32'd0);
    endtask

    initial begin
        longint exp_ticks;
        longint diff;
        bus.mute = 1'b0; bus.snd_l = 16'h8001; bus.snd_r = 16'h7FFE;
        bus_f.mute = 1'b0; bus_f.snd_l = 16'h0; bus_f.snd_r = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst = 1'b1;

        wait_frame();
        check("first_tick_next", 32'(first_nxt), 32'd1);
        check_frame("pat1a", 16'h8001, 16'h7FFE);
        check_frame("pat1b", 16'h8001, 16'h7FFE);

        // Mute mid-frame: current frame intact, next one silent, then restored.
        wait_t(200);
        bus.mute = 1'b1;
        check_frame("mute_cur", 16'h8001, 16'h7FFE);
        wait_t(200);
        bus.mute = 1'b0;
        wait_frame();
        check("mute_left",  32'(dec_l), 32'd0);
        check("mute_right", 32'(dec_r), 32'd0);
        check_frame("unmute", 16'h8001, 16'h7FFE);

        bus.snd_l = 16'hA5A5; bus.snd_r = 16'h1234;
        wait_frame();
        check_frame("pat2", 16'hA5A5, 16'h1234);
        bus.snd_l = 16'h0001; bus.snd_r = 16'hFFFF;
        wait_frame();
        check_frame("pat3", 16'h0001, 16'hFFFF);

        // Tick rate since the last reset release.
        exp_ticks = longint'((longint'(clk_cnt) * INC) >> 24);
        diff = tick_total - exp_ticks;
        check("tick_rate", 32'((diff >= -1) && (diff <= 1)), 32'd1);

        // Reset in the middle of a frame.
        wait_t(300);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_outputs("rst_mid");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        wait_frame();
        check("rst_first_next", 32'(first_nxt), 32'd1);
        check_frame("post_rst", 16'h0001, 16'hFFFF);

        check("orphan_next", 32'(orphan), 32'd0);
        check("f_gap_min", 32'(gap_min), 32'd4);
        check("f_gap_max", 32'(gap_max), 32'd4);
        check("f_bck_hi",  32'({hi_min[15:0], hi_max[15:0]}), {16'd16, 16'd16});
        check("f_bck_lo",  32'({lo_min[15:0], lo_max[15:0]}), {16'd16, 16'd16});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
